// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_dec_t;

endpackage

// File: rtl/pc_gen.sv
// Next-PC selection: +4 adder, pending-redirect register and target mux.
module pc_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        consume,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        pend_any
);

    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;

    assign pc_plus4 = pc + 32'd4;

    // A redirect arriving in the same cycle as a consume wins over older targets.
    always_comb begin
        tgt_d = tgt_q;
        if (redirect)
            tgt_d = redirect_pc & ~32'd3;
        pend_any = pend_q | redirect;
        pend_d   = pend_any & ~consume;
        next_pc  = pend_any ? tgt_d : pc_plus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            tgt_q  <= 32'd0;
        end else begin
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/DEC register, stall hold buffer and redirect drain.
// DELAY_SLOT_EN: deliver the word in flight at redirect time instead of squashing it.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        IMemReady,
    input  logic [31:0] IMemRData,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        InstrValid
);

`ifdef DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    localparam if_dec_t NOP_WORD = '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    if_dec_t      ifdec_q, ifdec_d;
    if_dec_t      hold_q, hold_d;
    if_dec_t      fetched;

    logic         fire, squash, consume, pend_any;
    logic [31:0]  pc_plus4, next_pc;

    assign fire   = req_q & IMemReady;
    assign squash = Redirect & ~DELAY_SLOT;

    pc_gen u_pc_gen (
        .clk        (Clock),
        .rst_n      (nReset),
        .pc         (pc_q),
        .redirect   (Redirect),
        .redirect_pc(RedirectPC),
        .consume    (consume),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .pend_any   (pend_any)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifdec_d = ifdec_q;
        hold_d  = hold_q;
        consume = 1'b0;
        fetched.instr = IMemRData;
        fetched.pc4   = pc_plus4;
        fetched.valid = 1'b1;
        if (squash)
            fetched = NOP_WORD;

        case (state_q)
            FETCH: begin
                if (fire) begin
                    consume = 1'b1;
                    if (Stall) begin
                        hold_d  = fetched;
                        state_d = HOLD;
                    end else begin
                        ifdec_d = fetched;
                    end
                end else begin
                    if (!Stall)
                        ifdec_d = NOP_WORD;
                    // Nothing outstanding (first cycle out of reset): redirect applies at once.
                    if (!req_q)
                        consume = pend_any;
                    else if (squash)
                        state_d = DRAIN;
                end
            end
            HOLD: begin
                consume = Redirect;
                if (squash)
                    hold_d = NOP_WORD;
                if (!Stall) begin
                    ifdec_d = squash ? NOP_WORD : hold_q;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (!Stall)
                    ifdec_d = NOP_WORD;
                if (fire) begin
                    consume = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (consume)
            pc_d = next_pc;
        req_d = (state_d != HOLD);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            ifdec_q <= NOP_WORD;
            hold_q  <= NOP_WORD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            ifdec_q <= ifdec_d;
            hold_q  <= hold_d;
        end
    end

    assign IMemReq     = req_q;
    assign IMemAddr    = pc_q;
    assign Instruction = ifdec_q.instr;
    assign PCPlus4     = ifdec_q.pc4;
    assign InstrValid  = ifdec_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_I  = 32'h0000_0000;

    logic        Clock, nReset, Stall, Redirect, IMemReady;
    logic [31:0] RedirectPC, IMemRData;
    logic        IMemReq, InstrValid;
    logic [31:0] IMemAddr, Instruction, PCPlus4;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP_I)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IMemReady  (IMemReady),
        .IMemRData  (IMemRData),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .Instruction(Instruction),
        .PCPlus4    (PCPlus4),
        .InstrValid (InstrValid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
        bit          v;
    } word_t;

    // Model: fetch address, request flag, at most one buffered word, drain flag.
    word_t       m_out;
    word_t       m_buf[$];
    logic [31:0] m_addr, m_tgt;
    bit          m_req, m_pend, m_discard;
    int          n_cmp, n_bad, cyc_no;

    function automatic word_t nop_w();
        word_t w;
        w.i = NOP_I;
        w.p = 32'd0;
        w.v = 1'b0;
        return w;
    endfunction

    task automatic model_reset();
        m_addr    = RST_PC;
        m_tgt     = 32'd0;
        m_req     = 1'b0;
        m_pend    = 1'b0;
        m_discard = 1'b0;
        m_buf.delete();
        m_out     = nop_w();
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                              input bit rdy, input logic [31:0] data);
        logic [31:0] tgt;
        bit          pend, kill, got;
        word_t       w;
        tgt  = rd ? (rpc & ~32'd3) : m_tgt;
        pend = m_pend | rd;
        kill = rd && !DS;
        got  = m_req && rdy;
        m_tgt  = tgt;
        m_pend = pend;
        if (m_buf.size() != 0) begin
            if (kill) m_buf[0] = nop_w();
            if (rd) begin m_addr = tgt; m_pend = 1'b0; end
            if (!st) m_out = m_buf.pop_front();
        end else if (m_discard) begin
            if (!st) m_out = nop_w();
            if (got) begin m_addr = tgt; m_pend = 1'b0; m_discard = 1'b0; end
        end else if (got) begin
            if (kill) w = nop_w();
            else begin w.i = data; w.p = m_addr + 32'd4; w.v = 1'b1; end
            if (st) m_buf.push_back(w);
            else    m_out = w;
            m_addr = pend ? tgt : m_addr + 32'd4;
            m_pend = 1'b0;
        end else begin
            if (!st) m_out = nop_w();
            if (!m_req && pend) begin m_addr = tgt; m_pend = 1'b0; end
            else if (m_req && kill) m_discard = 1'b1;
        end
        m_req = (m_buf.size() == 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req",   {31'd0, IMemReq},    {31'd0, m_req});
        chk("addr",  IMemAddr,            m_addr);
        chk("instr", Instruction,         m_out.i);
        chk("pc4",   PCPlus4,             m_out.p);
        chk("valid", {31'd0, InstrValid}, {31'd0, m_out.v});
    endtask

    task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        logic [31:0] data;
        data       = m_addr ^ 32'hA5A5_0000;
        Stall      = st;
        Redirect   = rd;
        RedirectPC = rpc;
        IMemReady  = rdy;
        IMemRData  = data;
        @(posedge Clock);
        model_step(st, rd, rpc, rdy, data);
        cyc_no++;
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, IMemReq},    32'd0);
        chk({tag, "_instr"}, Instruction,         NOP_I);
        chk({tag, "_pc4"},   PCPlus4,             32'd0);
        chk({tag, "_valid"}, {31'd0, InstrValid}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc_no = 0;
        nReset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'd0;
        IMemReady = 1'b0; IMemRData = 32'd0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_reset_outputs("rst");
        chk("rst_addr", IMemAddr, RST_PC);
        #1 nReset = 1'b1;

        // Streaming fetch with memory always ready.
        repeat (8) cyc(1'b0, 1'b0, 32'd0, 1'b1);

        // Stall while ready: one word buffered, then released.
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        chk("hold_noreq", {31'd0, IMemReq}, 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect to 0x40, then redirect to 0x100 while the 0x40 request waits.
        cyc(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        chk("at_40", IMemAddr, 32'h0000_0040);
        cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        repeat (3) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            chk("addr_stable", IMemAddr, 32'h0000_0040);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("redir_tgt", IMemAddr, 32'h0000_0100);
        chk("slot_valid", {31'd0, InstrValid}, {31'd0, DS});
        chk("slot_pc4", PCPlus4, DS ? 32'h0000_0044 : 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b1);

        // Address wrap at the top of the address space.
        cyc(1'b0, 1'b1, 32'hFFFF_FFFB, 1'b1);
        chk("wrap0", IMemAddr, 32'hFFFF_FFF8);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap1", IMemAddr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap2", IMemAddr, 32'h0000_0000);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom(), $urandom_range(0, 9) < 6);
        end

        // Asynchronous reset while a redirect is pending on an outstanding request.
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        #2 nReset = 1'b0;
        #1;
        check_reset_outputs("arst");
        chk("arst_addr", IMemAddr, RST_PC);
        @(posedge Clock);
        #2 nReset = 1'b1;
        model_reset();
        repeat (5) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("restart", IMemAddr, RST_PC + 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
